// File: rtl/prim_sec_anchor_pkg.sv
// prim_sec_anchor_pkg: shared state encoding and limits for the anchored state reader
package prim_sec_anchor_pkg;
  typedef enum logic [4:0] {
    IDLE   = 5'b00000,
    COMMIT = 5'b00111,
    CHECK  = 5'b11001,
    FATAL  = 5'b11110
  } state_e;
  localparam int MinScrubPeriod = 2;
endpackage

// File: rtl/prim_sec_anchor_reader_if.sv
// prim_sec_anchor_reader_if: write port, scrub request and read/alert outputs of the reader
interface prim_sec_anchor_reader_if #(
  parameter int Width   = 8,
  parameter int ErrCntW = 4
);
  logic               wr_valid_i;
  logic [Width-1:0]   wr_data_i;
  logic               wr_ready_o;
  logic               scrub_req_i;
  logic [Width-1:0]   rd_data_o;
  logic               rd_valid_o;
  logic               err_o;
  logic [ErrCntW-1:0] err_cnt_o;
  modport slave (
    input  wr_valid_i, wr_data_i, scrub_req_i,
    output wr_ready_o, rd_data_o, rd_valid_o, err_o, err_cnt_o
  );
  modport master (
    output wr_valid_i, wr_data_i, scrub_req_i,
    input  wr_ready_o, rd_data_o, rd_valid_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/prim_sec_anchor_flop.sv
// prim_sec_anchor_flop: enable flop bank kept as a distinct instance so redundant copies stay separate
module prim_sec_anchor_flop #(
  parameter int               Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);
  logic [Width-1:0] q_q;
  // hold value, load on enable, reset to the anchor value
  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= ResetValue;
    else if (en_i) q_q <= d_i;
  end
  assign q_o = q_q;
endmodule

// File: rtl/prim_sec_anchor_pair.sv
// prim_sec_anchor_pair: true and complemented copies in separate anchor flops plus their comparator
module prim_sec_anchor_pair #(
  parameter int               Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             true_en_i,
  input  logic [Width-1:0] true_d_i,
  input  logic             cpl_en_i,
  output logic [Width-1:0] true_o,
  output logic             consistent_o
);
  logic [Width-1:0] cpl_q;
  prim_sec_anchor_flop #(.Width(Width), .ResetValue(ResetValue)) u_true (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (true_en_i),
    .d_i   (true_d_i),
    .q_o   (true_o)
  );
  prim_sec_anchor_flop #(.Width(Width), .ResetValue(~ResetValue)) u_cpl (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (cpl_en_i),
    .d_i   (~true_o),
    .q_o   (cpl_q)
  );
  assign consistent_o = &(true_o ^ cpl_q);
endmodule

// File: rtl/prim_sec_anchor_reader.sv
// prim_sec_anchor_reader: hardened state register consumer with scrubbing and sticky fault reporting
module prim_sec_anchor_reader
  import prim_sec_anchor_pkg::*;
#(
  parameter int               Width       = 8,
  parameter logic [Width-1:0] ResetValue  = '0,
  parameter int               ScrubPeriod = 16,
  parameter int               ErrCntW     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  prim_sec_anchor_reader_if.slave  bus
);
  localparam int Period = (ScrubPeriod < MinScrubPeriod) ? MinScrubPeriod : ScrubPeriod;
  localparam int TimerW = $clog2(Period);
  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic [ErrCntW-1:0] cnt_q, cnt_d;
  logic [Width-1:0]   true_q;
  logic               consistent, idle, check, illegal, expired, scrub_trig, hs, fault;
  logic               wr_ready, rd_valid, cpl_en;
  prim_sec_anchor_pair #(.Width(Width), .ResetValue(ResetValue)) u_pair (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .true_en_i    (hs),
    .true_d_i     (bus.wr_data_i),
    .cpl_en_i     (cpl_en),
    .true_o       (true_q),
    .consistent_o (consistent)
  );
  assign idle       = state_q == IDLE;
  assign check      = state_q == CHECK;
  assign illegal    = !(state_q inside {IDLE, COMMIT, CHECK, FATAL});
  assign expired    = timer_q == TimerW'(Period - 1);
  assign scrub_trig = expired | bus.scrub_req_i | pend_q;
  assign hs         = bus.wr_valid_i & wr_ready;
  assign fault      = check & ~consistent;
  // state, scrub timer, pending scrub, sticky error and mismatch counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: a live mismatch beats a write, a write beats a scrub, unknown encodings lock up
  always_comb begin
    state_d = FATAL;
    case (state_q)
      IDLE:    state_d = !consistent ? CHECK : hs ? COMMIT : scrub_trig ? CHECK : IDLE;
      COMMIT:  state_d = IDLE;
      CHECK:   state_d = consistent ? IDLE : FATAL;
      default: state_d = FATAL;
    endcase
  end
  // handshake, read qualification and bookkeeping next values
  always_comb begin
    wr_ready = idle & consistent;
    rd_valid = (idle | check) & consistent;
    cpl_en   = state_q == COMMIT;
    timer_d  = check ? '0 : (idle && !expired) ? timer_q + 1'b1 : timer_q;
    pend_d   = check ? 1'b0 : pend_q | (hs & scrub_trig);
    err_d    = err_q | fault | illegal;
    cnt_d    = (fault && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  assign bus.wr_ready_o = wr_ready;
  assign bus.rd_valid_o = rd_valid;
  assign bus.rd_data_o  = rd_valid ? true_q : ResetValue;
  assign bus.err_o      = err_q;
  assign bus.err_cnt_o  = cnt_q;
endmodule

// File: tb/tb_prim_sec_anchor_reader.sv
// tb_prim_sec_anchor_reader: directed checks of write latency, scrubbing, fault detection and reset
module tb_prim_sec_anchor_reader;
  import prim_sec_anchor_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int fails = 0;
  int bad, nchk, seen;
  always #5 clk = ~clk;
  prim_sec_anchor_reader_if #(.Width(8), .ErrCntW(4)) bus ();
  prim_sec_anchor_reader #(
    .Width(8), .ResetValue(8'hA5), .ScrubPeriod(16), .ErrCntW(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.wr_valid_i  = 1'b0;
    bus.wr_data_i   = 8'h00;
    bus.scrub_req_i = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_ready", bus.wr_ready_o, 1);
    chk("rst_rdv", bus.rd_valid_o, 1);
    chk("rst_data", bus.rd_data_o, 8'hA5);
    chk("rst_err", bus.err_o, 0);
    chk("rst_cnt", bus.err_cnt_o, 0);
    bad = 0;
    nchk = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (dut.state_q == CHECK) nchk++;
      if (!(bus.rd_valid_o === 1'b1 && bus.rd_data_o === 8'hA5 && bus.err_o === 1'b0)) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    chk("idle_check_count", nchk, 2);
    chk("idle_err", bus.err_o, 0);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'h3C;
    chk("wr_ready_before", bus.wr_ready_o, 1);
    step(1);
    bus.wr_valid_i = 1'b0;
    chk("commit_ready", bus.wr_ready_o, 0);
    chk("commit_rdv", bus.rd_valid_o, 0);
    chk("commit_data", bus.rd_data_o, 8'hA5);
    step(1);
    chk("post_wr_rdv", bus.rd_valid_o, 1);
    chk("post_wr_data", bus.rd_data_o, 8'h3C);
    chk("post_wr_ready", bus.wr_ready_o, 1);
    bus.wr_valid_i  = 1'b1;
    bus.wr_data_i   = 8'h5A;
    bus.scrub_req_i = 1'b1;
    step(1);
    bus.wr_valid_i  = 1'b0;
    bus.scrub_req_i = 1'b0;
    chk("coll_commit_ready", bus.wr_ready_o, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (dut.state_q == CHECK) seen = 1;
    end
    chk("coll_check_seen", seen, 1);
    chk("coll_err", bus.err_o, 0);
    chk("coll_rdv", bus.rd_valid_o, 1);
    chk("coll_data", bus.rd_data_o, 8'h5A);
    force dut.u_pair.u_cpl.q_q = 8'hA4;
    #1;
    chk("flt_rdv_now", bus.rd_valid_o, 0);
    chk("flt_data_now", bus.rd_data_o, 8'hA5);
    step(1);
    chk("flt_rdv_check", bus.rd_valid_o, 0);
    step(1);
    chk("flt_err", bus.err_o, 1);
    chk("flt_cnt", bus.err_cnt_o, 1);
    bus.scrub_req_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!(bus.wr_ready_o === 1'b0 && bus.rd_valid_o === 1'b0 && bus.rd_data_o === 8'hA5 &&
            bus.err_o === 1'b1 && bus.err_cnt_o === 4'd1)) bad++;
    end
    chk("fatal_hold_bad", bad, 0);
    bus.scrub_req_i = 1'b0;
    release dut.u_pair.u_cpl.q_q;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst2_err", bus.err_o, 0);
    bus.wr_valid_i = 1'b1;
    bus.wr_data_i  = 8'h77;
    step(1);
    bus.wr_valid_i = 1'b0;
    chk("rstc_commit_ready", bus.wr_ready_o, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rstc_ready", bus.wr_ready_o, 1);
    chk("rstc_rdv", bus.rd_valid_o, 1);
    chk("rstc_data", bus.rd_data_o, 8'hA5);
    chk("rstc_err", bus.err_o, 0);
    chk("rstc_cnt", bus.err_cnt_o, 0);
    step(1);
    chk("rstc_data_hold", bus.rd_data_o, 8'hA5);
    chk("rstc_rdv_hold", bus.rd_valid_o, 1);
    force dut.state_q = state_e'(5'b10101);
    step(1);
    release dut.state_q;
    chk("ill_err", bus.err_o, 1);
    chk("ill_rdv", bus.rd_valid_o, 0);
    chk("ill_ready", bus.wr_ready_o, 0);
    step(1);
    chk("ill_fatal_rdv", bus.rd_valid_o, 0);
    chk("ill_fatal_ready", bus.wr_ready_o, 0);
    chk("ill_fatal_data", bus.rd_data_o, 8'hA5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
